// File: rtl/dual_port_ram.sv
// dual_port_ram: single-clock true dual-port RAM with byte enables,
// selectable write mode, optional output register and read-valid tracking.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cea,
    input  logic                               ceb,
    input  logic                               ocea,
    input  logic                               oceb,
    input  logic                               wrea,
    input  logic                               wreb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   bea,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   beb,
    input  logic [ADDR_WIDTH-1:0]              ada,
    input  logic [ADDR_WIDTH-1:0]              adb,
    input  logic [DATA_WIDTH-1:0]              dina,
    input  logic [DATA_WIDTH-1:0]              dinb,
    output logic [DATA_WIDTH-1:0]              douta,
    output logic [DATA_WIDTH-1:0]              doutb,
    output logic                               rvalida,
    output logic                               rvalidb,
    output logic                               collision
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam bit          PIPE  = (OUT_REG != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_a, wr_b, same_addr;
    logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b;
    logic [DATA_WIDTH-1:0] s1_d_a, s1_d_b, s1_d_a_nxt, s1_d_b_nxt;
    logic                  s1_v_a, s1_v_b, s1_v_a_nxt, s1_v_b_nxt;

    // Old words and the final merged words; port A lanes win on a shared address.
    always_comb begin
        wr_a      = cea & wrea & ~reset;
        wr_b      = ceb & wreb & ~reset;
        same_addr = (ada == adb);
        old_a     = mem[ada];
        old_b     = mem[adb];
        merged_a  = old_a;
        merged_b  = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (same_addr && wr_b && beb[i])
                merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && bea[i])
                merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_b && beb[i])
                merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (same_addr && wr_a && bea[i])
                merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Array update; both ports store the same merged word on a shared address.
    always_ff @(posedge clk) begin
        if (wr_a) mem[ada] <= merged_a;
        if (wr_b) mem[adb] <= merged_b;
    end

    // Stage-1 next data/valid per port according to access type and write mode.
    always_comb begin
        s1_d_a_nxt = s1_d_a;
        s1_d_b_nxt = s1_d_b;
        s1_v_a_nxt = 1'b0;
        s1_v_b_nxt = 1'b0;
        if (cea && !reset) begin
            if (!wrea) begin
                s1_d_a_nxt = old_a;
                s1_v_a_nxt = 1'b1;
            end else if (WRITE_MODE == 1) begin
                s1_d_a_nxt = merged_a;
                s1_v_a_nxt = 1'b1;
            end else if (WRITE_MODE == 2) begin
                s1_d_a_nxt = old_a;
                s1_v_a_nxt = 1'b1;
            end
        end
        if (ceb && !reset) begin
            if (!wreb) begin
                s1_d_b_nxt = old_b;
                s1_v_b_nxt = 1'b1;
            end else if (WRITE_MODE == 1) begin
                s1_d_b_nxt = merged_b;
                s1_v_b_nxt = 1'b1;
            end else if (WRITE_MODE == 2) begin
                s1_d_b_nxt = old_b;
                s1_v_b_nxt = 1'b1;
            end
        end
    end

    // Stage-1 registers; with an output register the valid stays pending until oce takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_d_a    <= '0;
            s1_d_b    <= '0;
            s1_v_a    <= 1'b0;
            s1_v_b    <= 1'b0;
            collision <= 1'b0;
        end else begin
            s1_d_a    <= s1_d_a_nxt;
            s1_d_b    <= s1_d_b_nxt;
            s1_v_a    <= s1_v_a_nxt | (PIPE & s1_v_a & ~ocea);
            s1_v_b    <= s1_v_b_nxt | (PIPE & s1_v_b & ~oceb);
            collision <= wr_a & wr_b & same_addr & (|(bea & beb));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q_a, q_b;
            logic                  v_a, v_b;

            // Output register stage, stalled by oce.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_a <= '0;
                    q_b <= '0;
                    v_a <= 1'b0;
                    v_b <= 1'b0;
                end else begin
                    if (ocea) q_a <= s1_d_a;
                    if (oceb) q_b <= s1_d_b;
                    v_a <= ocea & s1_v_a;
                    v_b <= oceb & s1_v_b;
                end
            end

            assign douta   = q_a;
            assign doutb   = q_b;
            assign rvalida = v_a;
            assign rvalidb = v_b;
        end else begin : g_bypass
            assign douta   = s1_d_a;
            assign doutb   = s1_d_b;
            assign rvalida = s1_v_a;
            assign rvalidb = s1_v_b;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: three configurations driven by shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_dual_port_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        cea, ceb, ocea, oceb, wrea, wreb;
    logic [3:0]  bea, beb;
    logic [11:0] ada, adb;
    logic [31:0] dina, dinb;

    logic [31:0] douta_w [3];
    logic [31:0] doutb_w [3];
    logic        rva_w   [3];
    logic        rvb_w   [3];
    logic        coll_w  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance k: WRITE_MODE = k; OUT_REG = 0 only for k = 1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dual_port_ram #(
            .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(12),
            .OUT_REG((g == 1) ? 0 : 1), .WRITE_MODE(g)
        ) u_dut (
            .clk(clk), .reset(reset),
            .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
            .wrea(wrea), .wreb(wreb), .bea(bea), .beb(beb),
            .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
            .douta(douta_w[g]), .doutb(doutb_w[g]),
            .rvalida(rva_w[g]), .rvalidb(rvb_w[g]),
            .collision(coll_w[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Behavioural model state
    logic [31:0] ref_mem   [4096];
    bit          ref_known [4096];
    logic [31:0] m_s1   [3][2];
    bit          m_s1k  [3][2];
    bit          m_pend [3][2];
    logic [31:0] m_out  [3][2];
    bit          m_outk [3][2];
    bit          m_rv   [3][2];
    bit          m_coll;

    // Model: apply B's write then A's write, derive each port's result from the rules.
    always @(posedge clk) begin : model
        logic [31:0] old_w [2];
        bit          old_k [2];
        logic [31:0] fin_w [2];
        bit          fin_k [2];
        bit          ce [2], we [2], oce [2];
        logic [3:0]  be [2];
        logic [11:0] ad [2];
        logic [31:0] din [2];
        logic [31:0] nd;
        bit          nk, nv;
        ce[0] = cea;   ce[1] = ceb;
        we[0] = wrea;  we[1] = wreb;
        oce[0] = ocea; oce[1] = oceb;
        be[0] = bea;   be[1] = beb;
        ad[0] = ada;   ad[1] = adb;
        din[0] = dina; din[1] = dinb;
        if (reset) begin
            m_coll = 1'b0;
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    m_s1[k][p] = '0;  m_s1k[k][p] = 1'b1; m_pend[k][p] = 1'b0;
                    m_out[k][p] = '0; m_outk[k][p] = 1'b1; m_rv[k][p] = 1'b0;
                end
        end else begin
            for (int p = 0; p < 2; p++) begin
                old_w[p] = ref_mem[ad[p]];
                old_k[p] = ref_known[ad[p]];
            end
            m_coll = ce[0] && we[0] && ce[1] && we[1] && (ad[0] == ad[1]) && ((be[0] & be[1]) != 0);
            for (int p = 1; p >= 0; p--)
                if (ce[p] && we[p]) begin
                    ref_mem[ad[p]]   = merge(ref_mem[ad[p]], din[p], be[p]);
                    ref_known[ad[p]] = ref_known[ad[p]] || (be[p] == 4'hF);
                end
            for (int p = 0; p < 2; p++) begin
                fin_w[p] = ref_mem[ad[p]];
                fin_k[p] = ref_known[ad[p]];
            end
            for (int k = 0; k < 3; k++)
                for (int p = 0; p < 2; p++) begin
                    nd = m_s1[k][p]; nk = m_s1k[k][p]; nv = 1'b0;
                    if (ce[p]) begin
                        if (!we[p])      begin nd = old_w[p]; nk = old_k[p]; nv = 1'b1; end
                        else if (k == 1) begin nd = fin_w[p]; nk = fin_k[p]; nv = 1'b1; end
                        else if (k == 2) begin nd = old_w[p]; nk = old_k[p]; nv = 1'b1; end
                    end
                    if (k == 1) begin
                        m_out[k][p] = nd; m_outk[k][p] = nk; m_rv[k][p] = nv;
                    end else begin
                        m_rv[k][p] = oce[p] && m_pend[k][p];
                        if (oce[p]) begin
                            m_out[k][p]  = m_s1[k][p];
                            m_outk[k][p] = m_s1k[k][p];
                        end
                        m_pend[k][p] = nv || (m_pend[k][p] && !oce[p]);
                    end
                    m_s1[k][p] = nd; m_s1k[k][p] = nk;
                end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.rvalida", k), 32'(rva_w[k]), 32'(m_rv[k][0]));
            check($sformatf("u%0d.rvalidb", k), 32'(rvb_w[k]), 32'(m_rv[k][1]));
            if (m_outk[k][0]) check($sformatf("u%0d.douta", k), douta_w[k], m_out[k][0]);
            if (m_outk[k][1]) check($sformatf("u%0d.doutb", k), doutb_w[k], m_out[k][1]);
            check($sformatf("u%0d.collision", k), 32'(coll_w[k]), 32'(m_coll));
        end
    end

    task automatic acc(input int p, input bit we, input logic [3:0] be,
                       input logic [11:0] ad, input logic [31:0] d);
        if (p == 0) begin cea = 1'b1; wrea = we; bea = be; ada = ad; dina = d; end
        else        begin ceb = 1'b1; wreb = we; beb = be; adb = ad; dinb = d; end
    endtask

    task automatic go();
        @(negedge clk);
        cea = 1'b0;
        ceb = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cea = 1'b0; ceb = 1'b0; ocea = 1'b1; oceb = 1'b1;
        wrea = 1'b0; wreb = 1'b0; bea = '0; beb = '0; ada = '0; adb = '0;
        dina = '0; dinb = '0;
        go(); go();
        check("rst douta", douta_w[0], 32'h0);
        check("rst rvalida", 32'(rva_w[0]), 32'h0);
        check("rst collision", 32'(coll_w[0]), 32'h0);
        reset = 1'b0;

        // Known contents for every address used below
        for (int a = 0; a < 16; a++) begin
            acc(0, 1, 4'hF, 12'(a), 32'h0);
            acc(1, 1, 4'hF, 12'(a + 16), 32'h0);
            go();
        end
        acc(0, 1, 4'hF, 12'h3FF, 32'h1234_5678); go(); go(); go();

        // Basic write then cross-port read
        acc(0, 1, 4'hF, 12'h010, 32'hDEAD_BEEF); go();
        check("wr douta hold", douta_w[0], 32'h0);
        check("wr rvalida", 32'(rva_w[0]), 32'h0);
        acc(1, 0, 4'h0, 12'h010, 32'h0); go();
        check("rd1 u0 rvalidb early", 32'(rvb_w[0]), 32'h0);
        check("rd1 u1 doutb", doutb_w[1], 32'hDEAD_BEEF);
        go();
        check("rd2 u0 doutb", doutb_w[0], 32'hDEAD_BEEF);
        check("rd2 u0 rvalidb", 32'(rvb_w[0]), 32'h1);
        go();
        check("rd2 u0 rvalidb pulse", 32'(rvb_w[0]), 32'h0);

        // Byte enables
        acc(0, 1, 4'hF, 12'd5, 32'h1122_3344); go();
        acc(0, 1, 4'b0101, 12'd5, 32'hAABB_CCDD); go();
        acc(0, 0, 4'h0, 12'd5, 32'h0); go();
        check("be u1 douta", douta_w[1], 32'h11BB_33DD);
        go();
        check("be u0 douta", douta_w[0], 32'h11BB_33DD);

        // Write modes
        acc(0, 1, 4'hF, 12'd7, 32'h1); go();
        acc(0, 0, 4'h0, 12'd7, 32'h0); go(); go();
        acc(0, 1, 4'hF, 12'd7, 32'h2); go();
        check("wm1 douta", douta_w[1], 32'h2);
        check("wm1 rvalida", 32'(rva_w[1]), 32'h1);
        go();
        check("wm2 douta", douta_w[2], 32'h1);
        check("wm2 rvalida", 32'(rva_w[2]), 32'h1);
        check("wm0 douta", douta_w[0], 32'h1);
        check("wm0 rvalida", 32'(rva_w[0]), 32'h0);

        // Cross-port collision
        acc(0, 1, 4'b1100, 12'h3FF, 32'hFFFF_0000);
        acc(1, 1, 4'b0110, 12'h3FF, 32'h1234_5678); go();
        check("coll pulse", 32'(coll_w[0]), 32'h1);
        check("coll wt douta", douta_w[1], 32'hFFFF_5678);
        check("coll wt doutb", doutb_w[1], 32'hFFFF_5678);
        go();
        check("coll one cycle", 32'(coll_w[0]), 32'h0);
        acc(0, 0, 4'h0, 12'h3FF, 32'h0); go(); go();
        check("coll readback", douta_w[0], 32'hFFFF_5678);
        acc(0, 1, 4'b1100, 12'h3FF, 32'hFFFF_0000);
        acc(1, 1, 4'b0011, 12'h3FF, 32'h1234_5678); go();
        check("nocoll", 32'(coll_w[0]), 32'h0);
        acc(1, 0, 4'h0, 12'h3FF, 32'h0); go(); go();
        check("nocoll readback", doutb_w[0], 32'hFFFF_5678);

        // Read during write across ports
        acc(0, 1, 4'hF, 12'd9, 32'h0000_CAFE); go();
        acc(0, 1, 4'hF, 12'd9, 32'h0000_BEEF);
        acc(1, 0, 4'h0, 12'd9, 32'h0); go();
        check("rdw old doutb", doutb_w[1], 32'h0000_CAFE);
        check("rdw wt douta", douta_w[1], 32'h0000_BEEF);
        acc(1, 0, 4'h0, 12'd9, 32'h0); go();
        check("rdw new doutb", doutb_w[1], 32'h0000_BEEF);

        // oce stall
        acc(0, 1, 4'hF, 12'd1, 32'h101);
        acc(1, 1, 4'hF, 12'd2, 32'h202); go();
        acc(0, 1, 4'hF, 12'd3, 32'h303); go(); go(); go();
        acc(0, 0, 4'h0, 12'd1, 32'h0); go();
        acc(0, 0, 4'h0, 12'd2, 32'h0); go();
        check("oce first douta", douta_w[0], 32'h101);
        check("oce first rvalida", 32'(rva_w[0]), 32'h1);
        acc(0, 0, 4'h0, 12'd3, 32'h0); ocea = 1'b0; go();
        check("oce stall douta", douta_w[0], 32'h101);
        check("oce stall rvalida", 32'(rva_w[0]), 32'h0);
        ocea = 1'b1; go();
        check("oce resume douta", douta_w[0], 32'h303);
        check("oce resume rvalida", 32'(rva_w[0]), 32'h1);

        // Reset mid-stream
        acc(0, 0, 4'h0, 12'd1, 32'h0); go();
        reset = 1'b1; go();
        check("mid rst u0 douta", douta_w[0], 32'h0);
        check("mid rst u0 rvalida", 32'(rva_w[0]), 32'h0);
        check("mid rst u1 douta", douta_w[1], 32'h0);
        reset = 1'b0;
        acc(0, 0, 4'h0, 12'd1, 32'h0); go(); go();
        check("post rst douta", douta_w[0], 32'h101);
        check("post rst rvalida", 32'(rva_w[0]), 32'h1);

        // Randomized traffic on a small address window
        for (int n = 0; n < 2000; n++) begin
            cea  = ($urandom_range(0, 3) != 0);
            ceb  = ($urandom_range(0, 3) != 0);
            wrea = 1'($urandom_range(0, 1));
            wreb = 1'($urandom_range(0, 1));
            bea  = 4'($urandom_range(0, 15));
            beb  = 4'($urandom_range(0, 15));
            ada  = 12'($urandom_range(0, 31));
            adb  = ($urandom_range(0, 2) == 0) ? ada : 12'($urandom_range(0, 31));
            dina = $urandom;
            dinb = $urandom;
            ocea = ($urandom_range(0, 4) != 0);
            oceb = ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        cea = 1'b0; ceb = 1'b0; reset = 1'b0; ocea = 1'b1; oceb = 1'b1;
        go(); go(); go();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
